// File: rtl/itr_ctrl.sv
// itr_ctrl - interrupt controller in front of the core's single itr input.
//
// Latches rising edges on NSRC request lines as pending. A pending source is
// eligible when its mask bit and the global enable are both set. The lowest
// eligible index wins, and the controller issues a one-cycle itr pulse.
// Further interrupts are held off until software strobes eoi. After that, a
// guard gap of GAPCYC idle cycles passes before the controller re-arms.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous reset, active low
//   src_i       request lines, rising-edge sensitive
//   hold_i      core not interruptible this cycle; defers firing
//   eoi_i       end-of-interrupt strobe, honoured only while in service
//   cfg_wr_i    load configuration register from cfg_data_i
//   cfg_data_i  [NSRC] global enable, [NSRC-1:0] mask (1 = enabled)
//   itr_o       interrupt pulse to the core, one cycle wide
//   vec_o       index of the source being serviced; held until next fire
//   pend_o      raw pending flags (mask not applied)
//   in_srv_o    high from the itr cycle until eoi is accepted
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | armed; fires on the first cycle with eligible work and no hold
// S_FIRE   | itr pulse cycle; vec already points at the winner
// S_SERVICE| waiting for software eoi; other edges only pend
// S_GAP    | guard gap after eoi; cnt_q counts down to zero
module itr_ctrl #(
  parameter  int NSRC   = 4,
  parameter  int GAPCYC = 2,
  localparam int NBVEC  = $clog2(NSRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NSRC-1:0]  src_i,
  input  logic             hold_i,
  input  logic             eoi_i,
  input  logic             cfg_wr_i,
  input  logic [NSRC:0]    cfg_data_i,
  output logic             itr_o,
  output logic [NBVEC-1:0] vec_o,
  output logic [NSRC-1:0]  pend_o,
  output logic             in_srv_o
);

  // The counter only ever holds GAPCYC-1 down to 0.
  localparam int CW = (GAPCYC > 1) ? $clog2(GAPCYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRE    = 2'd1,
    S_SERVICE = 2'd2,
    S_GAP     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [NSRC-1:0]  src_q;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC:0]    cfg_q, cfg_d;
  logic [NBVEC-1:0] vec_q, vec_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NSRC-1:0]  elig;
  logic [NSRC-1:0]  win_oh;
  logic [NBVEC-1:0] winner;
  logic [NSRC-1:0]  clr;

  // Fixed priority: scan from the top so the lowest set index is kept last.
  always_comb begin
    elig   = pend_q & cfg_q[NSRC-1:0] & {NSRC{cfg_q[NSRC]}};
    winner = '0;
    win_oh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner    = NBVEC'(i);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    clr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if ((|elig) && !hold_i) begin
          state_d = S_FIRE;
          vec_d   = winner;
          clr     = win_oh;
        end
      end
      S_FIRE: state_d = S_SERVICE;
      S_SERVICE: begin
        if (eoi_i) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAPCYC - 1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new edge on the source being cleared re-pends it (set beats clear).
  // Arbitration above reads cfg_q, so a same-cycle cfg write applies next cycle.
  always_comb begin
    pend_d = (pend_q & ~clr) | (src_i & ~src_q);
    cfg_d  = cfg_wr_i ? cfg_data_i : cfg_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      pend_q  <= '0;
      cfg_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_i;
      pend_q  <= pend_d;
      cfg_q   <= cfg_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  assign itr_o    = (state_q == S_FIRE);
  assign in_srv_o = (state_q == S_FIRE) || (state_q == S_SERVICE);
  assign vec_o    = vec_q;
  assign pend_o   = pend_q;

endmodule

// File: tb/tb_itr_ctrl.sv
module tb_itr_ctrl;
  localparam int NSRC   = 4;
  localparam int GAPCYC = 2;
  localparam int NBVEC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NSRC-1:0]  src;
  logic             hold, eoi, cfg_wr;
  logic [NSRC:0]    cfg_data;
  logic             itr, in_srv;
  logic [NBVEC-1:0] vec;
  logic [NSRC-1:0]  pend;

  int checks   = 0;
  int failures = 0;
  int itr_count;

  itr_ctrl #(.NSRC(NSRC), .GAPCYC(GAPCYC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .hold_i(hold), .eoi_i(eoi),
    .cfg_wr_i(cfg_wr), .cfg_data_i(cfg_data), .itr_o(itr), .vec_o(vec),
    .pend_o(pend), .in_srv_o(in_srv)
  );

  always #5 clk = ~clk;

  // Reference model: pending set, config, and a service timeline.
  // m_busy_fire : the current cycle is the itr cycle
  // m_waiting   : awaiting eoi
  // m_quiet     : idle cycles still to pass before arbitration resumes
  bit [NSRC-1:0] m_prev, m_pend;
  bit [NSRC:0]   m_cfg;
  int            m_vec;
  bit            m_busy_fire, m_waiting;
  int            m_quiet;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_cfg = '0; m_vec = 0;
    m_busy_fire = 0; m_waiting = 0; m_quiet = 0;
  endtask

  task automatic model_edge();
    bit [NSRC-1:0] elig, edges, take;
    bit armed, fire;
    int w;
    elig  = m_pend & m_cfg[NSRC-1:0] & {NSRC{m_cfg[NSRC]}};
    edges = src & ~m_prev;
    armed = !m_busy_fire && !m_waiting && (m_quiet == 0);
    fire  = armed && (elig != 0) && !hold;
    take  = '0;
    if (fire) begin
      w = 0;
      for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) w = i;
      take    = NSRC'(1) << w;
      m_vec   = w;
    end
    m_pend = (m_pend & ~take) | edges;
    if (m_busy_fire) m_waiting = 1;
    else if (m_waiting && eoi) begin
      m_waiting = 0;
      m_quiet   = GAPCYC;
    end else if (m_quiet > 0) m_quiet--;
    m_busy_fire = fire;
    m_prev = src;
    if (cfg_wr) m_cfg = cfg_data;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [NSRC-1:0] s, input logic h, input logic e,
                     input logic w, input logic [NSRC:0] d);
    src = s; hold = h; eoi = e; cfg_wr = w; cfg_data = d;
    @(posedge clk);
    model_edge();
    #1;
    check("itr", 32'(itr), 32'(m_busy_fire));
    check("in_srv", 32'(in_srv), 32'(m_busy_fire || m_waiting));
    check("pend", 32'(pend), 32'(m_pend));
    check("vec", 32'(vec), 32'(m_vec));
    if (itr === 1'b1) itr_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic reset_dut(input logic [NSRC-1:0] s);
    rst_n = 1'b0; src = s; hold = 0; eoi = 0; cfg_wr = 0; cfg_data = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_itr", 32'(itr), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_in_srv", 32'(in_srv), 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NSRC-1:0] rs;
    itr_count = 0;
    model_reset();

    // 1: reset with all sources high; release counts as an edge
    reset_dut(4'b1111);
    cyc(4'b1111, 0, 0, 0, '0);
    check("release_edge_pend", 32'(pend), 32'h0000000f);
    reset_dut(4'b0000);

    // 2: single source, full latency and gap
    cyc(4'b0000, 0, 0, 1, 5'b1_1111);
    idle(2);
    cyc(4'b0100, 0, 0, 0, '0);
    check("t2_pend_set", 32'(pend), 32'h4);
    check("t2_no_itr_yet", 32'(itr), 32'd0);
    cyc(4'b0000, 0, 0, 0, '0);
    check("t2_itr", 32'(itr), 32'd1);
    check("t2_vec", 32'(vec), 32'd2);
    check("t2_pend_clr", 32'(pend), 32'd0);
    idle(1);
    check("t2_itr_single", 32'(itr), 32'd0);
    check("t2_in_srv", 32'(in_srv), 32'd1);
    idle(5);
    cyc(4'b0000, 0, 1, 0, '0);
    check("t2_in_srv_drop", 32'(in_srv), 32'd0);
    idle(3);

    // 3: priority between simultaneous edges
    itr_count = 0;
    cyc(4'b1010, 0, 0, 0, '0);
    cyc(4'b0000, 0, 0, 0, '0);
    check("t3_first_vec", 32'(vec), 32'd1);
    idle(3);
    cyc(4'b0000, 0, 1, 0, '0);
    idle(GAPCYC + 1);
    check("t3_second_itr", 32'(itr), 32'd1);
    check("t3_second_vec", 32'(vec), 32'd3);
    idle(2);
    cyc(4'b0000, 0, 1, 0, '0);
    idle(6);
    check("t3_itr_count", 32'(itr_count), 32'd2);

    // 4: mask then hold
    cyc(4'b0000, 0, 0, 1, 5'b1_1110);
    cyc(4'b0001, 0, 0, 0, '0);
    idle(3);
    check("t4_masked_pend", 32'(pend[0]), 32'd1);
    itr_count = 0;
    cyc(4'b0000, 1, 0, 1, 5'b1_1111);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 1, 0, 0, '0);
    check("t4_held_no_itr", 32'(itr_count), 32'd0);
    cyc(4'b0000, 0, 0, 0, '0);
    check("t4_itr_after_hold", 32'(itr), 32'd1);
    check("t4_vec", 32'(vec), 32'd0);
    idle(2);
    cyc(4'b0000, 0, 1, 0, '0);
    idle(4);

    // 5: re-edge in the cycle the pending bit is cleared
    itr_count = 0;
    cyc(4'b0010, 1, 0, 0, '0);
    cyc(4'b0000, 1, 0, 0, '0);
    cyc(4'b0010, 0, 0, 0, '0);
    check("t5_itr", 32'(itr), 32'd1);
    check("t5_repend", 32'(pend), 32'h2);
    idle(2);
    cyc(4'b0000, 0, 1, 0, '0);
    idle(GAPCYC + 1);
    check("t5_second_vec", 32'(vec), 32'd1);
    idle(1);
    cyc(4'b0000, 0, 1, 0, '0);
    idle(4);
    check("t5_itr_count", 32'(itr_count), 32'd2);

    // 6: reset in the middle of service
    cyc(4'b1010, 0, 0, 0, '0);
    cyc(4'b0000, 0, 0, 0, '0);
    cyc(4'b0000, 0, 0, 0, '0);
    check("t6_pend_before", 32'(pend), 32'h8);
    check("t6_in_srv_before", 32'(in_srv), 32'd1);
    reset_dut(4'b0000);
    itr_count = 0;
    cyc(4'b0000, 0, 0, 1, 5'b1_1111);
    idle(10);
    check("t6_no_itr", 32'(itr_count), 32'd0);

    // Random traffic against the model
    reset_dut(4'b0000);
    cyc(4'b0000, 0, 0, 1, 5'b1_1111);
    rs = '0;
    for (int i = 0; i < 800; i++) begin
      logic [NSRC:0] d;
      rs = rs ^ NSRC'($urandom & $urandom);
      d  = {($urandom_range(0, 7) != 0), NSRC'($urandom)};
      cyc(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 29) == 0), d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
